// File: rtl/e_operand_stage.sv
// D->E pipeline register with M/W operand forwarding.
// Generates load-use stalls and drives ALU operands.
module e_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [4:0]  d_dst,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  input  logic [15:0] d_imm,
  input  logic        d_use_imm,
  input  logic        d_imm_zext,
  input  logic [5:0]  d_alufunc,
  input  logic        d_regwrite,
  input  logic        d_memread,
  input  logic        x_stall,
  input  logic        e_flush,
  input  logic        m_regwrite,
  input  logic [4:0]  m_dst,
  input  logic [31:0] m_valE,
  input  logic        w_regwrite,
  input  logic [4:0]  w_dst,
  input  logic [31:0] w_val,
  output logic [31:0] e_aluA,
  output logic [31:0] e_aluB,
  output logic [5:0]  e_alufunc,
  output logic [31:0] e_rt_fwd,
  output logic [4:0]  e_dst,
  output logic        e_valid,
  output logic        e_regwrite,
  output logic        e_memread,
  output logic        d_stall
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ext_imm;
    logic        use_imm;
    logic [5:0]  alufunc;
    logic        regwrite;
    logic        memread;
  } e_reg_t;

  localparam logic [5:0] FUNC_ADD = 6'b100000;

  e_reg_t e_q;
  e_reg_t bubble;
  e_reg_t cap;

  logic load_use;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // Bubble value and the decoded D slot with W bypass applied
  always_comb begin
    bubble         = '0;
    bubble.alufunc = FUNC_ADD;

    cap          = '0;
    cap.valid    = 1'b1;
    cap.rs       = d_rs;
    cap.rt       = d_rt;
    cap.dst      = d_dst;
    cap.use_imm  = d_use_imm;
    cap.alufunc  = d_alufunc;
    cap.regwrite = d_regwrite;
    cap.memread  = d_memread;
    cap.ext_imm  = d_imm_zext ? {16'b0, d_imm}
                              : {{16{d_imm[15]}}, d_imm};
    cap.rs_val   = d_rs_val;
    cap.rt_val   = d_rt_val;
    if (w_regwrite && w_dst != 5'd0 && w_dst == d_rs)
      cap.rs_val = w_val;
    if (w_regwrite && w_dst != 5'd0 && w_dst == d_rt)
      cap.rt_val = w_val;
  end

  // Independent M-over-W forwarding for rs and rt
  always_comb begin
    fwd_rs = e_q.rs_val;
    if (m_regwrite && m_dst != 5'd0 && m_dst == e_q.rs)
      fwd_rs = m_valE;
    else if (w_regwrite && w_dst != 5'd0 && w_dst == e_q.rs)
      fwd_rs = w_val;

    fwd_rt = e_q.rt_val;
    if (m_regwrite && m_dst != 5'd0 && m_dst == e_q.rt)
      fwd_rt = m_valE;
    else if (w_regwrite && w_dst != 5'd0 && w_dst == e_q.rt)
      fwd_rt = w_val;
  end

  // Load-use detection; rt compare is always made
  always_comb begin
    load_use = e_q.valid && e_q.memread &&
               e_q.dst != 5'd0 && d_valid &&
               (d_rs == e_q.dst || d_rt == e_q.dst);
    d_stall  = x_stall || (load_use && !e_flush);
  end

  // E register: reset, freeze, flush/load-use bubble, capture
  always_ff @(posedge clk) begin
    if (!rst_n)
      e_q <= bubble;
    else if (x_stall)
      e_q <= e_q;
    else if (e_flush || load_use)
      e_q <= bubble;
    else if (d_valid)
      e_q <= cap;
    else
      e_q <= bubble;
  end

  assign e_aluB     = fwd_rs;
  assign e_aluA     = e_q.use_imm ? e_q.ext_imm : fwd_rt;
  assign e_rt_fwd   = fwd_rt;
  assign e_alufunc  = e_q.alufunc;
  assign e_dst      = e_q.dst;
  assign e_valid    = e_q.valid;
  assign e_regwrite = e_q.regwrite;
  assign e_memread  = e_q.memread;

endmodule

// File: tb/tb_e_operand_stage.sv
// Directed bench for e_operand_stage.
// Checks capture, forwarding, stalls, flush and reset.
module tb_e_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [31:0] d_rs_val, d_rt_val;
  logic [15:0] d_imm;
  logic        d_use_imm, d_imm_zext;
  logic [5:0]  d_alufunc;
  logic        d_regwrite, d_memread;
  logic        x_stall, e_flush;
  logic        m_regwrite;
  logic [4:0]  m_dst;
  logic [31:0] m_valE;
  logic        w_regwrite;
  logic [4:0]  w_dst;
  logic [31:0] w_val;
  logic [31:0] e_aluA, e_aluB, e_rt_fwd;
  logic [5:0]  e_alufunc;
  logic [4:0]  e_dst;
  logic        e_valid, e_regwrite, e_memread;
  logic        d_stall;

  int compared = 0;
  int mismatched = 0;

  e_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_dst(d_dst),
    .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_imm(d_imm), .d_use_imm(d_use_imm),
    .d_imm_zext(d_imm_zext), .d_alufunc(d_alufunc),
    .d_regwrite(d_regwrite), .d_memread(d_memread),
    .x_stall(x_stall), .e_flush(e_flush),
    .m_regwrite(m_regwrite), .m_dst(m_dst),
    .m_valE(m_valE), .w_regwrite(w_regwrite),
    .w_dst(w_dst), .w_val(w_val),
    .e_aluA(e_aluA), .e_aluB(e_aluB),
    .e_alufunc(e_alufunc), .e_rt_fwd(e_rt_fwd),
    .e_dst(e_dst), .e_valid(e_valid),
    .e_regwrite(e_regwrite), .e_memread(e_memread),
    .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, "_aluA"}, e_aluA, 32'h0);
    chk({tag, "_aluB"}, e_aluB, 32'h0);
    chk({tag, "_rtf"}, e_rt_fwd, 32'h0);
    chk({tag, "_func"}, 32'(e_alufunc), 32'h20);
    chk({tag, "_dst"}, 32'(e_dst), 32'h0);
    chk({tag, "_valid"}, 32'(e_valid), 32'h0);
    chk({tag, "_rw"}, 32'(e_regwrite), 32'h0);
    chk({tag, "_mr"}, 32'(e_memread), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; d_valid = 1'b0;
    d_rs = '0; d_rt = '0; d_dst = '0;
    d_rs_val = '0; d_rt_val = '0; d_imm = '0;
    d_use_imm = 1'b0; d_imm_zext = 1'b0;
    d_alufunc = 6'h20; d_regwrite = 1'b0;
    d_memread = 1'b0; x_stall = 1'b0; e_flush = 1'b0;
    m_regwrite = 1'b0; m_dst = '0; m_valE = '0;
    w_regwrite = 1'b0; w_dst = '0; w_val = '0;

    step(); step();
    check_bubble("reset");
    chk("reset_dstall", 32'(d_stall), 32'h0);

    // add r3 = r1 + r2
    rst_n = 1'b1;
    d_valid = 1'b1; d_rs = 5'd1; d_rt = 5'd2;
    d_dst = 5'd3; d_rs_val = 32'd5; d_rt_val = 32'd3;
    d_alufunc = 6'h20; d_regwrite = 1'b1;
    step();
    chk("add_aluB", e_aluB, 32'd5);
    chk("add_aluA", e_aluA, 32'd3);
    chk("add_valid", 32'(e_valid), 32'h1);
    chk("add_dst", 32'(e_dst), 32'd3);

    // immediate sign / zero extension
    d_use_imm = 1'b1; d_imm = 16'hFFFF;
    d_imm_zext = 1'b0;
    step();
    chk("sext_aluA", e_aluA, 32'hFFFF_FFFF);
    chk("sext_rtf", e_rt_fwd, 32'd3);
    d_imm_zext = 1'b1;
    step();
    chk("zext_aluA", e_aluA, 32'h0000_FFFF);

    // forwarding on E.rs = 4 (stored 7)
    d_use_imm = 1'b0; d_rs = 5'd4; d_rs_val = 32'd7;
    d_dst = 5'd5;
    step();
    chk("fwd_none", e_aluB, 32'd7);
    m_regwrite = 1'b1; m_dst = 5'd4; m_valE = 32'd10;
    w_regwrite = 1'b1; w_dst = 5'd4; w_val = 32'd20;
    #1;
    chk("fwd_m_pri", e_aluB, 32'd10);
    m_regwrite = 1'b0;
    #1;
    chk("fwd_w", e_aluB, 32'd20);
    m_regwrite = 1'b1; m_dst = 5'd0;
    w_dst = 5'd0;
    #1;
    chk("fwd_r0", e_aluB, 32'd7);
    // capture-time W bypass on rs
    w_dst = 5'd4; m_regwrite = 1'b0;
    step();
    w_regwrite = 1'b0;
    #1;
    chk("cap_bypass", e_aluB, 32'd20);

    // load r7 then dependent consumer
    d_rs = 5'd1; d_rt = 5'd2; d_dst = 5'd7;
    d_rs_val = 32'd5; d_memread = 1'b1;
    step();
    d_rs = 5'd7; d_rt = 5'd0; d_dst = 5'd8;
    d_rs_val = 32'd0; d_rt_val = 32'd4;
    d_memread = 1'b0; d_alufunc = 6'h22;
    #1;
    chk("lu_stall", 32'(d_stall), 32'h1);
    chk("lu_mr", 32'(e_memread), 32'h1);
    step();
    chk("lu_bub_valid", 32'(e_valid), 32'h0);
    chk("lu_bub_func", 32'(e_alufunc), 32'h20);
    chk("lu_bub_stall", 32'(d_stall), 32'h0);
    step();
    w_regwrite = 1'b1; w_dst = 5'd7; w_val = 32'd99;
    #1;
    chk("lu_w_aluB", e_aluB, 32'd99);
    chk("lu_valid", 32'(e_valid), 32'h1);
    chk("lu_func", 32'(e_alufunc), 32'h22);
    chk("lu_aluA", e_aluA, 32'd4);
    w_regwrite = 1'b0;

    // freeze for three cycles
    x_stall = 1'b1;
    d_rs = 5'd1; d_rs_val = 32'd55; d_alufunc = 6'h24;
    #1;
    chk("xs_dstall", 32'(d_stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("xs_aluA", e_aluA, 32'd4);
      chk("xs_aluB", e_aluB, 32'd0);
      chk("xs_func", 32'(e_alufunc), 32'h22);
      chk("xs_dst", 32'(e_dst), 32'd8);
    end
    x_stall = 1'b0;

    // flush coincident with load-use
    d_rs = 5'd1; d_rt = 5'd2; d_dst = 5'd7;
    d_memread = 1'b1; d_alufunc = 6'h20;
    step();
    d_rs = 5'd7; d_memread = 1'b0; d_dst = 5'd9;
    e_flush = 1'b1;
    #1;
    chk("fl_dstall", 32'(d_stall), 32'h0);
    step();
    chk("fl_valid", 32'(e_valid), 32'h0);
    chk("fl_func", 32'(e_alufunc), 32'h20);
    e_flush = 1'b0;

    // reset during a stall
    d_rs = 5'd1; d_rs_val = 32'd5; d_dst = 5'd3;
    step();
    chk("pre_rst_valid", 32'(e_valid), 32'h1);
    x_stall = 1'b1; rst_n = 1'b0;
    step();
    check_bubble("rst_stall");
    chk("rst_dstall_x", 32'(d_stall), 32'h1);
    x_stall = 1'b0;
    #1;
    chk("rst_dstall", 32'(d_stall), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/e_operand_stage.md
# e_operand_stage

D→E pipeline register and operand-forwarding front end that drives the execute-stage ALU inputs `e_aluA`, `e_aluB` and `e_alufunc`. It captures decoded instructions and generates load-use stalls and bubbles. It resolves RAW hazards by forwarding from the M and W stages, and applies the operand ordering the ALU expects.

## Interface
Parameters: none (32-bit datapath, 5-bit register numbers, 6-bit function code fixed).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `d_valid`  in  1  decode slot holds an instruction
- `d_rs`, `d_rt`, `d_dst`  in  5  source and destination register numbers
- `d_rs_val`, `d_rt_val`  in  32  register-file read data
- `d_imm`  in  16  immediate field
- `d_use_imm`  in  1  A operand is the immediate
- `d_imm_zext`  in  1  zero-extend the immediate (else sign-extend)
- `d_alufunc`  in  6  ALU function code
- `d_regwrite`, `d_memread`  in  1  writes a register / is a load
- `x_stall`  in  1  global freeze (memory wait)
- `e_flush`  in  1  squash the D slot (branch redirect)
- `m_regwrite`  in  1  M-stage forwarding source valid
- `m_dst`  in  5  M-stage destination register
- `m_valE`  in  32  M-stage ALU result
- `w_regwrite`  in  1  W-stage forwarding source valid
- `w_dst`  in  5  W-stage destination register
- `w_val`  in  32  W-stage writeback value
- `e_aluA`, `e_aluB`  out  32  ALU operands
- `e_alufunc`  out  6  ALU function code
- `e_rt_fwd`  out  32  forwarded rt value (store data)
- `e_dst`  out  5  E-stage destination register
- `e_valid`, `e_regwrite`, `e_memread`  out  1  E-stage control
- `d_stall`  out  1  hold the PC and the D register this cycle

## Operation
- E register fields: valid, rs, rt, dst, rs_val, rt_val, ext_imm (32 bits), use_imm, alufunc, regwrite, memread.
- Immediate extension happens at capture: `d_imm_zext`=1 gives `{16'b0,d_imm}`; otherwise `{{16{d_imm[15]}},d_imm}`.
- Capture-time bypass applies when `w_regwrite`, `w_dst`≠0 and `w_dst`==`d_rs`: the E register stores `w_val` instead of `d_rs_val`. The same rule applies to rt.
- Operand ordering is fixed:
  - `e_aluB` = forwarded rs.
  - `e_aluA` = ext_imm when use_imm, else forwarded rt.
  - Subtract therefore yields rs−rt, and slt yields rs<rt.
- Forwarding for rs and rt is evaluated independently each cycle:
  - M match (`m_regwrite`, `m_dst`≠0, `m_dst`==E.rs or E.rt) selects `m_valE`.
  - Otherwise a W match selects `w_val`.
  - Otherwise the stored value is used.
  - M has priority over W. Register 0 is never forwarded.
- `e_rt_fwd` = forwarded rt, regardless of use_imm.
- Load-use condition = E.valid & E.memread & E.dst≠0 & `d_valid` & (`d_rs`==E.dst | `d_rt`==E.dst). The rt comparison is always made; a spurious stall is acceptable.
- Next-state priority on each rising edge:
  1. `rst_n`=0: bubble.
  2. `x_stall`=1: hold the E register unchanged.
  3. `e_flush`=1: bubble.
  4. Load-use: bubble.
  5. Otherwise capture the D slot; `d_valid`=0 captures a bubble.
- Bubble: valid, regwrite and memread = 0; dst, rs and rt = 0; all values = 0; use_imm = 0; alufunc = 6'b100000 (add).
- `d_stall` = `x_stall` | (load-use & ~`e_flush`).

## Timing
- Reset values: all E fields take the bubble values. As a result:
  - `e_aluA`, `e_aluB`, `e_rt_fwd` = 0 (provided no forwarding source matches register 0, which cannot occur).
  - `e_alufunc` = 6'b100000.
  - `e_dst`, `e_valid`, `e_regwrite`, `e_memread` = 0.
  - `d_stall` depends only on `x_stall` during reset.
- Latency: an instruction presented in D in cycle n drives the ALU in cycle n+1.
- Forwarding muxes and `d_stall` are combinational within the cycle. There is no path from `e_aluA`/`e_aluB` back to `d_stall`.
- Load followed by a dependent instruction:
  - Cycle n: the load is in E; `d_stall`=1.
  - Cycle n+1: a bubble is in E and the load is in M. M forwarding is never used for load data because of the bubble.
  - Cycle n+2: the consumer is in E and takes the load data from W.
- Simultaneous `e_flush` and load-use: flush wins and `d_stall`=0.
- Simultaneous `x_stall` with anything else: the E register holds and `d_stall`=1. Forwarding still re-evaluates each cycle against the live M/W inputs.
- Reset asserted mid-stall or mid-flush: bubble on the next edge, with no residual state.

## Test plan
- Reset then add, with rs=1 (val 5) and rt=2 (val 3), func 100000 → next cycle `e_aluB`=5, `e_aluA`=3, `e_valid`=1.
- Immediate extension with `d_imm`=16'hFFFF:
  - `d_imm_zext`=0 → `e_aluA`=32'hFFFF_FFFF.
  - `d_imm_zext`=1 → `e_aluA`=32'h0000_FFFF.
- E.rs=4 with M (dst 4, `m_valE`=10) and W (dst 4, `w_val`=20) both matching → `e_aluB`=10. With `m_regwrite`=0 → `e_aluB`=20. With dst=0 → the stored value is used.
- E holds a load to r7 and D reads r7 → `d_stall`=1 for exactly one cycle, then a bubble (`e_valid`=0, `e_alufunc`=100000), then the consumer reaches E with W forwarding (`w_val`=99 → operand 99).
- `x_stall` held for 3 cycles → E outputs remain constant.
- `e_flush` coincident with load-use → bubble, with `d_stall`=0.
- `rst_n` low during a stall → all outputs return to their reset values on the next edge.
